// File: rtl/midi_voice_rx.sv
// midi_voice_rx: MIDI 1.0 serial receiver and polyphonic voice allocator.
// Define MIDI_RX_STEAL_EN to steal the oldest voice when every voice is busy.
module midi_voice_rx #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int NUM_VOICES   = 8,
  parameter int VEL_W        = 3,
  parameter int WAVE_W       = 2,
  parameter int MIDI_CH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        midi_in,
  output logic [NUM_VOICES-1:0]       voice_on,
  output logic [NUM_VOICES*7-1:0]     voice_note,
  output logic [NUM_VOICES*VEL_W-1:0] voice_vel,
  output logic [WAVE_W-1:0]           wave_out,
  output logic                        byte_valid,
  output logic [7:0]                  byte_data,
  output logic                        frame_err,
  output logic                        voice_drop
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_t;

  rx_t           state;
  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      s1         <= midi_in;
      s2         <= s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + CW'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!s2) state <= START;
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          if (s2) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: if (cnt == FULL) begin
          cnt     <= '0;
          shreg   <= {s2, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (cnt == FULL) begin
          cnt <= '0;
          if (s2) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg;
            state      <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_HI;
          end
        end
        default: begin
          cnt <= '0;
          if (s2) state <= IDLE;
        end
      endcase
    end
  end

  logic [7:0] status;
  logic       rs_valid;
  logic       dcnt;
  logic [6:0] d1;

  logic is_rt, is_sx, is_st, is_dat, two_byte, ch_ok, complete;
  logic on_msg, off_msg, pc_msg, ano_msg;
  logic [6:0] key, vin;

  assign is_rt    = byte_data[7:3] == 5'b11111;
  assign is_sx    = byte_data[7:3] == 5'b11110;
  assign is_st    = byte_data[7] && byte_data[7:4] != 4'hF;
  assign is_dat   = !byte_data[7];
  assign two_byte = !(status[7:4] == 4'hC || status[7:4] == 4'hD);
  assign ch_ok    = (MIDI_CH >= 16) || (status[3:0] == 4'(MIDI_CH));
  assign complete = byte_valid && is_dat && rs_valid && (dcnt || !two_byte);
  assign key      = d1;
  assign vin      = byte_data[6:0];

  assign on_msg  = complete && ch_ok && status[7:4] == 4'h9 && vin != 7'd0;
  assign off_msg = complete && ch_ok &&
                   (status[7:4] == 4'h8 || (status[7:4] == 4'h9 && vin == 7'd0));
  assign pc_msg  = complete && ch_ok && status[7:4] == 4'hC;
  assign ano_msg = complete && ch_ok && status[7:4] == 4'hB && key == 7'd123;

  logic [NUM_VOICES-1:0] hit;
  logic                  free_any, alloc_en, drop_en;
  logic [IW-1:0]         free_idx, alloc_idx;

`ifdef MIDI_RX_STEAL_EN
  logic [7:0]    age [NUM_VOICES];
  logic [7:0]    old_age;
  logic [IW-1:0] old_idx;
`endif

  always_comb begin
    hit       = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    alloc_en  = 1'b0;
    alloc_idx = '0;
    drop_en   = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      hit[i] = voice_on[i] && voice_note[7*i +: 7] == key;
      if (!voice_on[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
`ifdef MIDI_RX_STEAL_EN
    old_age = age[0];
    old_idx = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > old_age) begin
        old_age = age[i];
        old_idx = IW'(i);
      end
    end
`endif
    if (on_msg && hit == '0) begin
      if (free_any) begin
        alloc_en  = 1'b1;
        alloc_idx = free_idx;
      end else begin
`ifdef MIDI_RX_STEAL_EN
        alloc_en  = 1'b1;
        alloc_idx = old_idx;
`else
        drop_en   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= '0;
      rs_valid   <= 1'b0;
      dcnt       <= 1'b0;
      d1         <= '0;
      voice_on   <= '0;
      voice_note <= '0;
      voice_vel  <= '0;
      wave_out   <= '0;
      voice_drop <= 1'b0;
`ifdef MIDI_RX_STEAL_EN
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
`endif
    end else begin
      voice_drop <= drop_en;
      if (byte_valid) begin
        unique case (1'b1)
          is_rt: ;
          is_sx: begin
            rs_valid <= 1'b0;
            dcnt     <= 1'b0;
          end
          is_st: begin
            status   <= byte_data;
            rs_valid <= 1'b1;
            dcnt     <= 1'b0;
          end
          is_dat: if (rs_valid) begin
            if (complete) begin
              dcnt <= 1'b0;
            end else begin
              d1   <= vin;
              dcnt <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (on_msg && hit[i])
          voice_vel[VEL_W*i +: VEL_W] <= vin[6 -: VEL_W];
        if (alloc_en && alloc_idx == IW'(i)) begin
          voice_note[7*i +: 7]        <= key;
          voice_vel[VEL_W*i +: VEL_W] <= vin[6 -: VEL_W];
          voice_on[i]                 <= 1'b1;
        end
        if (off_msg && hit[i]) voice_on[i] <= 1'b0;
        if (ano_msg) voice_on[i] <= 1'b0;
`ifdef MIDI_RX_STEAL_EN
        // Age counts allocations since this voice was claimed, saturating.
        if (alloc_en) begin
          if (alloc_idx == IW'(i)) age[i] <= '0;
          else if (voice_on[i] && age[i] != 8'hFF) age[i] <= age[i] + 8'd1;
        end
`endif
      end
      if (pc_msg) wave_out <= vin[WAVE_W-1:0];
    end
  end
endmodule

// File: tb/tb_midi_voice_rx.sv
// tb_midi_voice_rx: directed and random MIDI byte streams against a
// message-level reference model of the voice bank.
module tb_midi_voice_rx;
  localparam int CPB = 8;
  localparam int NV  = 8;
  localparam int VW  = 3;
  localparam int WW  = 2;
  localparam int CH  = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              midi_in = 1'b1;
  logic [NV-1:0]     voice_on;
  logic [NV*7-1:0]   voice_note;
  logic [NV*VW-1:0]  voice_vel;
  logic [WW-1:0]     wave_out;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;
  logic              voice_drop;

  midi_voice_rx #(
    .CLKS_PER_BIT(CPB), .NUM_VOICES(NV), .VEL_W(VW),
    .WAVE_W(WW), .MIDI_CH(CH)
  ) dut (
    .clk(clk), .rst(rst), .midi_in(midi_in),
    .voice_on(voice_on), .voice_note(voice_note),
    .voice_vel(voice_vel), .wave_out(wave_out),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_err(frame_err), .voice_drop(voice_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit   m_on[NV];
  int   m_note[NV], m_vel[NV], m_ts[NV];
  int   m_wave, m_alloc, m_st, m_cnt, m_d1;
  bit   m_rsv;
  int   bv_exp = 0, fe_exp = 0, vd_exp = 0;
  int   bv_cnt = 0, fe_cnt = 0, vd_cnt = 0;
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_on[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_ts[i] = 0;
    end
    m_wave = 0; m_alloc = 0; m_st = 0; m_cnt = 0; m_d1 = 0; m_rsv = 0;
  endfunction

  function automatic void grab(int i, int k, int v);
    m_on[i] = 1; m_note[i] = k; m_vel[i] = v >> (7 - VW);
    m_ts[i] = m_alloc;
    m_alloc++;
  endfunction

  function automatic void note_on(int k, int v);
    bit hit = 0;
    int best, best_age, a;
    for (int i = 0; i < NV; i++)
      if (m_on[i] && m_note[i] == k) begin
        m_vel[i] = v >> (7 - VW);
        hit = 1;
      end
    if (hit) return;
    for (int i = 0; i < NV; i++)
      if (!m_on[i]) begin
        grab(i, k, v);
        return;
      end
`ifdef MIDI_RX_STEAL_EN
    best = 0; best_age = -1;
    for (int i = 0; i < NV; i++) begin
      a = m_alloc - m_ts[i] - 1;
      if (a > 255) a = 255;
      if (a > best_age) begin best_age = a; best = i; end
    end
    grab(best, k, v);
`else
    best = 0; best_age = 0; a = 0;
    vd_exp++;
`endif
  endfunction

  function automatic void model_byte(int b);
    int need, hi;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin m_rsv = 0; m_cnt = 0; return; end
    if (b >= 'h80) begin m_st = b; m_rsv = 1; m_cnt = 0; return; end
    if (!m_rsv) return;
    hi = m_st >> 4;
    need = (hi == 'hC || hi == 'hD) ? 1 : 2;
    if (m_cnt + 1 < need) begin m_d1 = b; m_cnt++; return; end
    m_cnt = 0;
    if (CH < 16 && (m_st & 15) != CH) return;
    if (hi == 9 && b != 0) note_on(m_d1, b);
    else if (hi == 8 || hi == 9) begin
      for (int i = 0; i < NV; i++)
        if (m_on[i] && m_note[i] == m_d1) m_on[i] = 0;
    end else if (hi == 'hC) m_wave = b % (1 << WW);
    else if (hi == 'hB && m_d1 == 123)
      for (int i = 0; i < NV; i++) m_on[i] = 0;
  endfunction

  task automatic check_state(string tag);
    logic [NV-1:0]    eon;
    logic [NV*7-1:0]  en;
    logic [NV*VW-1:0] ev;
    for (int i = 0; i < NV; i++) begin
      eon[i] = m_on[i];
      en[7*i +: 7] = 7'(m_note[i]);
      ev[VW*i +: VW] = VW'(m_vel[i]);
    end
    chk({tag, ".on"}, 64'(voice_on), 64'(eon));
    chk({tag, ".note"}, 64'(voice_note), 64'(en));
    chk({tag, ".vel"}, 64'(voice_vel), 64'(ev));
    chk({tag, ".wave"}, 64'(wave_out), 64'(m_wave));
  endtask

  task automatic send_byte(logic [7:0] b, bit good);
    if (good) begin exp_q.push_back(b); bv_exp++; end
    else fe_exp++;
    @(negedge clk) midi_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_in = good;
    repeat (CPB) @(negedge clk);
    midi_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (good) model_byte(int'(b));
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    midi_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        bv_cnt++;
        if (exp_q.size() == 0) chk("byte_extra", 64'd1, 64'd0);
        else chk("byte_data", 64'(byte_data), 64'(exp_q.pop_front()));
      end
      if (frame_err) fe_cnt++;
      if (voice_drop) vd_cnt++;
    end
  end

  logic [7:0] b;
  int r;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({byte_valid, frame_err, voice_drop, byte_data}), 64'd0);
    check_state("rst");
    rst = 1'b0;

    send_seq('{8'h90, 8'h3C, 8'h7F});
    chk("on0.gate", 64'(voice_on[0]), 64'd1);
    chk("on0.note", 64'(voice_note[6:0]), 64'h3C);
    chk("on0.vel", 64'(voice_vel[VW-1:0]), 64'd7);
    chk("on0.bv", 64'(bv_cnt), 64'd3);

    send_seq('{8'h40, 8'h40});
    check_state("rs_on");
    chk("rs_two", 64'(voice_on[1:0]), 64'd3);
    send_seq('{8'h3C, 8'h00});
    check_state("rs_off");
    chk("rs_off_v", 64'(voice_on[1:0]), 64'd2);

    send_seq('{8'hC0, 8'h05});
    chk("wave", 64'(wave_out), 64'd1);
    send_seq('{8'h90, 8'hF8, 8'h3E, 8'h50});
    check_state("rt_mid");
    send_seq('{8'h90, 8'h50, 8'h10, 8'h51, 8'h20});
    chk("four_on", 64'($countones(voice_on)), 64'd4);
    send_seq('{8'hB0, 8'h7B, 8'h00});
    chk("all_off", 64'(voice_on), 64'd0);

    do_reset();
    send_byte(8'h90, 1'b1);
    for (int n = 0; n < 9; n++) begin
      send_byte(8'(40 + n), 1'b1);
      send_byte(8'h7F, 1'b1);
    end
    check_state("nine");
`ifdef MIDI_RX_STEAL_EN
    chk("nine.v0", 64'(voice_note[6:0]), 64'd48);
`else
    chk("nine.v0", 64'(voice_note[6:0]), 64'd40);
`endif
    chk("nine.drop", 64'(vd_cnt), 64'(vd_exp));

    send_byte(8'h55, 1'b0);
    chk("ferr", 64'(fe_cnt), 64'(fe_exp));
    send_seq('{8'hC0, 8'h02});
    chk("after_ferr", 64'(wave_out), 64'd2);

    @(negedge clk) midi_in = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    do_reset();
    chk("midrst_outs", 64'({byte_valid, frame_err, voice_drop, byte_data}), 64'd0);
    check_state("midrst");
    repeat (2 * CPB) @(negedge clk);
    send_seq('{8'h90, 8'h3C, 8'h7F});
    check_state("post_rst");

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        case ($urandom_range(0, 8))
          0: b = 8'h80; 1, 2, 3: b = 8'h90; 4: b = 8'hA0;
          5: b = 8'hB0; 6: b = 8'hC0; 7: b = 8'hD0; default: b = 8'hE0;
        endcase
        if ($urandom_range(0, 3) == 0) b[0] = 1'b1;
      end else if (r < 88) begin
        case ($urandom_range(0, 9))
          6: b = 8'd0;
          7: b = 8'd123;
          8, 9: b = 8'($urandom_range(0, 127));
          default: b = 8'(60 + $urandom_range(0, 9));
        endcase
      end else if (r < 94) b = 8'(8'hF8 + $urandom_range(0, 7));
      else b = 8'(8'hF0 + $urandom_range(0, 7));
      send_byte(b, $urandom_range(0, 99) >= 3);
      check_state("rand");
    end

    chk("bv_total", 64'(bv_cnt), 64'(bv_exp));
    chk("fe_total", 64'(fe_cnt), 64'(fe_exp));
    chk("vd_total", 64'(vd_cnt), 64'(vd_exp));
    chk("q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
